apb_ctrl_regs: RTL and testbench

Parametrised APB3 control/status register block for the BNN accelerator. It sits between the processor's APB bus and the systolic array controller. It generates the weight-transfer and start pulses and holds the active-array bounds. Unlike the earlier write-only block, it adds:
- readback of all registers
- a sticky done flag with interrupt
- configurable wait states
- address/access error reporting

---
 rtl/apb_ctrl_regs.sv | 150 +++++++++++++++
 tb/tb_apb_ctrl_regs.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ctrl_regs.sv
// apb_ctrl_regs
//   APB3 control/status register block for the BNN accelerator. It sits
//   between the processor APB bus and the systolic array controller.
//
//   Register map (byte offsets, paddr[4:0] decoded):
//     0x00 CTRL     W   bit0 -> weight_transfer pulse, bit1 -> start pulse
//     0x04 LAST_ROW RW  [DIM_W-1:0]
//     0x08 LAST_COL RW  [DIM_W-1:0]
//     0x0C STATUS       bit0 array_busy (RO), bit1 done (sticky, W1C)
//     0x10 IRQ_EN   RW  bit0
//     0x14 VERSION  RO
//
//   Ports:
//     clk, resetn                 clock, asynchronous active-low reset
//     s_apb_*                     APB3 slave (paddr, psel, penable, pwrite,
//                                 pwdata in; pready, prdata, pslverr out)
//     array_busy, array_done      status from the array controller
//     weight_transfer, start      one-cycle command pulses
//     last_row, last_col          active-array bounds
//     irq                         level interrupt (irq_en & done, registered)
module apb_ctrl_regs #(
  parameter int unsigned DIM_W       = 5,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] VERSION     = 32'h0001_0000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      s_apb_paddr,
  input  logic             s_apb_psel,
  input  logic             s_apb_penable,
  input  logic             s_apb_pwrite,
  input  logic [31:0]      s_apb_pwdata,
  output logic             s_apb_pready,
  output logic [31:0]      s_apb_prdata,
  output logic             s_apb_pslverr,
  input  logic             array_busy,
  input  logic             array_done,
  output logic             weight_transfer,
  output logic             start,
  output logic [DIM_W-1:0] last_row,
  output logic [DIM_W-1:0] last_col,
  output logic             irq
);

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_ROW     = 5'h04;
  localparam logic [4:0] OFF_COL     = 5'h08;
  localparam logic [4:0] OFF_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_IRQ_EN  = 5'h10;
  localparam logic [4:0] OFF_VERSION = 5'h14;
  localparam logic [3:0] WS          = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic        done;
  logic        irq_en;

  logic [4:0]  off;
  logic        complete;
  logic        addr_err;
  logic        wr_ok;
  logic        done_clr;
  logic [31:0] rdata;
  logic        unused_bits;

  assign off         = s_apb_paddr[4:0];
  assign unused_bits = ^{s_apb_paddr[31:5], s_apb_pwdata[31:DIM_W]};

  // Only an ACCESS phase can complete; this keeps a bus left in the
  // enable phase across reset from completing a stale transfer.
  assign s_apb_pready = (state == ACCESS) & s_apb_psel & s_apb_penable & (wcnt == WS);
  assign complete     = s_apb_pready;

  assign addr_err = (off[1:0] != 2'b00) | (off > OFF_VERSION) |
                    (s_apb_pwrite & (off == OFF_VERSION));
  assign wr_ok    = complete & s_apb_pwrite & ~addr_err;
  assign done_clr = wr_ok & (off == OFF_STATUS) & s_apb_pwdata[1];

  always_comb begin
    rdata = '0;
    case (off)
      OFF_ROW:     rdata[DIM_W-1:0] = last_row;
      OFF_COL:     rdata[DIM_W-1:0] = last_col;
      OFF_STATUS:  rdata[1:0]       = {done, array_busy};
      OFF_IRQ_EN:  rdata[0]         = irq_en;
      OFF_VERSION: rdata            = VERSION;
      default:     rdata            = '0;
    endcase
  end

  // Read data and error are only driven during the completing cycle.
  assign s_apb_prdata  = (complete & ~s_apb_pwrite & ~addr_err) ? rdata : '0;
  assign s_apb_pslverr = complete & addr_err;

  // Wait-state FSM: setup moves to ACCESS, completion or a dropped psel
  // returns to IDLE so a back-to-back setup is seen the very next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_apb_psel & ~s_apb_penable) begin
            state <= ACCESS;
            wcnt  <= '0;
          end
        end
        ACCESS: begin
          if (~s_apb_psel | complete) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (s_apb_penable & (wcnt != WS)) begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // Register file, command pulses and interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_row        <= '0;
      last_col        <= '0;
      irq_en          <= 1'b0;
      done            <= 1'b0;
      irq             <= 1'b0;
      weight_transfer <= 1'b0;
      start           <= 1'b0;
    end else begin
      weight_transfer <= wr_ok & (off == OFF_CTRL) & s_apb_pwdata[0];
      start           <= wr_ok & (off == OFF_CTRL) & s_apb_pwdata[1];
      if (wr_ok & (off == OFF_ROW))    last_row <= s_apb_pwdata[DIM_W-1:0];
      if (wr_ok & (off == OFF_COL))    last_col <= s_apb_pwdata[DIM_W-1:0];
      if (wr_ok & (off == OFF_IRQ_EN)) irq_en   <= s_apb_pwdata[0];
      // A new done event beats a simultaneous W1C.
      if (array_done)    done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      irq <= irq_en & done;
    end
  end

endmodule

// File: tb/tb_apb_ctrl_regs.sv
module tb_apb_ctrl_regs;
  localparam int unsigned DIM_W = 5;
  localparam int unsigned WS    = 3;
  localparam logic [31:0] VER   = 32'h0001_0000;

  logic             clk;
  logic             resetn;
  logic [31:0]      paddr;
  logic             psel, penable, pwrite;
  logic [31:0]      pwdata;
  logic             pready;
  logic [31:0]      prdata;
  logic             pslverr;
  logic             array_busy, array_done;
  logic             wt, start;
  logic [DIM_W-1:0] last_row, last_col;
  logic             irq;

  int tests = 0;
  int fails = 0;

  apb_ctrl_regs #(.DIM_W(DIM_W), .WAIT_STATES(WS), .VERSION(VER)) dut (
    .clk(clk), .resetn(resetn),
    .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
    .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
    .array_busy(array_busy), .array_done(array_done),
    .weight_transfer(wt), .start(start),
    .last_row(last_row), .last_col(last_col), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; starts the setup phase immediately and returns at
  // posedge+1 of the cycle after the completion edge.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input bit done_at_end, output logic [31:0] rd, output logic err);
    int nwait;
    bit got;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    nwait = 0; got = 1'b0; rd = '0; err = 1'b0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk);
      if (pready) begin
        got = 1'b1; rd = prdata; err = pslverr;
        if (done_at_end) array_done = 1'b1;
      end else begin
        nwait++;
      end
      @(posedge clk); #1;
    end
    array_done = 1'b0; psel = 1'b0; penable = 1'b0;
    if (!got) chk("xfer_timeout", 32'd0, 32'd1);
    else      chk("wait_states", 32'(nwait), 32'(WS));
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  // Behavioural register model
  logic [DIM_W-1:0] m_row, m_col;
  bit               m_irqen, m_done;

  logic [31:0] rd;
  logic        err;

  initial begin
    bit          wr, busy, m_err, exp_wt, exp_st;
    logic [4:0]  off;
    logic [31:0] addr, wd, exp_rd;

    vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h14, 32'h0, VER,   1'b0});
    vecs.push_back('{1'b1, 32'h04, 32'hFFFF_FFE7, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 32'h7, 1'b0});
    vecs.push_back('{1'b1, 32'h00, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h08, 32'h0000_0015, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h15, 1'b0});
    vecs.push_back('{1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 32'h1, 1'b0});
    vecs.push_back('{1'b1, 32'h10, 32'hFFFF_FFFE, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h18, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h06, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h1C, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h14, 32'h1234_5678, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h06, 32'h0000_001F, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0A, 32'h0000_001F, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h18, 32'h0000_001F, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 32'h7, 1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h15, 1'b0});
    vecs.push_back('{1'b0, 32'h14, 32'h0, VER, 1'b0});
    vecs.push_back('{1'b1, 32'h0C, 32'h0000_0001, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0104, 32'h0, 32'h7, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_1001, 32'h0, 32'h0, 1'b1});

    resetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; array_busy = 1'b0; array_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wt", 32'(wt), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_row", 32'(last_row), 0);
    chk("rst_col", 32'(last_col), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_pready", 32'(pready), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Table-driven register access
    for (int i = 0; i < vecs.size(); i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_nopulse", i), 32'({wt, start}), 0);
    end
    chk("tbl_row", 32'(last_row), 32'h07);
    chk("tbl_col", 32'(last_col), 32'h15);
    chk("tbl_irq", 32'(irq), 0);

    // CTRL pulses
    apb_xfer(1'b1, 32'h00, 32'h3, 1'b0, rd, err);
    chk("ctrl3_wt", 32'(wt), 1);
    chk("ctrl3_start", 32'(start), 1);
    @(posedge clk); #1;
    chk("ctrl3_pulse_end", 32'({wt, start}), 0);
    apb_xfer(1'b1, 32'h00, 32'h2, 1'b0, rd, err);
    chk("ctrl2_pulse", 32'({wt, start}), 32'h1);
    @(posedge clk); #1;
    chk("ctrl2_pulse_end", 32'({wt, start}), 0);

    // Wait states visible cycle by cycle
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1D;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < int'(WS); i++) begin
      @(negedge clk);
      chk("ws_pready_low", 32'(pready), 0);
      chk("ws_col_hold", 32'(last_col), 32'h15);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ws_pready_high", 32'(pready), 1);
    chk("ws_col_before", 32'(last_col), 32'h15);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("ws_col_after", 32'(last_col), 32'h1D);

    // Abort mid-wait: no update
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h03;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    idle(3);
    chk("abort_col", 32'(last_col), 32'h1D);
    apb_xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err);
    chk("abort_readback", rd, 32'h1D);

    // Done / interrupt
    apb_xfer(1'b1, 32'h10, 32'h1, 1'b0, rd, err);
    chk("irq_idle", 32'(irq), 0);
    array_done = 1'b1; @(posedge clk); #1; array_done = 1'b0;
    chk("irq_not_yet", 32'(irq), 0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 1);
    array_busy = 1'b1;
    apb_xfer(1'b0, 32'h0C, 32'h0, 1'b0, rd, err);
    chk("status_busy_done", rd, 32'h3);
    array_busy = 1'b0;
    apb_xfer(1'b1, 32'h0C, 32'h2, 1'b1, rd, err);
    apb_xfer(1'b0, 32'h0C, 32'h0, 1'b0, rd, err);
    chk("set_wins", rd, 32'h2);
    chk("set_wins_irq", 32'(irq), 1);
    apb_xfer(1'b1, 32'h0C, 32'h2, 1'b0, rd, err);
    chk("irq_hold_one", 32'(irq), 1);
    @(posedge clk); #1;
    chk("irq_fall", 32'(irq), 0);
    apb_xfer(1'b0, 32'h0C, 32'h0, 1'b0, rd, err);
    chk("status_cleared", rd, 32'h0);

    // Asynchronous reset during a pending CTRL write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h3;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("arst_row", 32'(last_row), 0);
    chk("arst_col", 32'(last_col), 0);
    chk("arst_pulses", 32'({wt, start}), 0);
    chk("arst_pready", 32'(pready), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < int'(WS) + 3; i++) begin
      @(negedge clk);
      chk("arst_no_complete", 32'(pready), 0);
      chk("arst_no_pulse", 32'({wt, start}), 0);
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    apb_xfer(1'b0, 32'h10, 32'h0, 1'b0, rd, err);
    chk("arst_irq_en", rd, 0);

    // Randomized traffic against the register model
    m_row = '0; m_col = '0; m_irqen = 1'b0; m_done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        array_done = 1'b1; @(posedge clk); #1; array_done = 1'b0;
        m_done = 1'b1;
      end
      busy = 1'($urandom_range(0, 1));
      array_busy = busy;
      wr  = 1'($urandom_range(0, 1));
      off = 5'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 7) == 0) off = 5'($urandom);
      addr = {27'($urandom), off};
      wd   = $urandom;

      m_err = (off[1:0] != 2'b00) || (off > 5'h14) || (wr && off == 5'h14);
      case (off)
        5'h04:   exp_rd = 32'(m_row);
        5'h08:   exp_rd = 32'(m_col);
        5'h0C:   exp_rd = {30'd0, m_done, busy};
        5'h10:   exp_rd = {31'd0, m_irqen};
        5'h14:   exp_rd = VER;
        default: exp_rd = 32'h0;
      endcase
      if (m_err) exp_rd = 32'h0;
      exp_wt = wr && !m_err && off == 5'h00 && wd[0];
      exp_st = wr && !m_err && off == 5'h00 && wd[1];
      if (wr && !m_err) begin
        if (off == 5'h04) m_row = wd[DIM_W-1:0];
        if (off == 5'h08) m_col = wd[DIM_W-1:0];
        if (off == 5'h0C && wd[1]) m_done = 1'b0;
        if (off == 5'h10) m_irqen = wd[0];
      end

      apb_xfer(wr, addr, wd, 1'b0, rd, err);
      chk($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
      if (!wr) chk($sformatf("rnd%0d_rd", n), rd, exp_rd);
      chk($sformatf("rnd%0d_pulses", n), 32'({wt, start}), 32'({exp_wt, exp_st}));
      chk($sformatf("rnd%0d_row", n), 32'(last_row), 32'(m_row));
      chk($sformatf("rnd%0d_col", n), 32'(last_col), 32'(m_col));
      if ($urandom_range(0, 3) == 0) begin
        idle(2);
        chk($sformatf("rnd%0d_irq", n), 32'(irq), 32'(m_irqen & m_done));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
